pwm_fault_sequencer: RTL and testbench
======================================

# pwm_fault_sequencer

Supervisory start-up and fault-retry sequencer for the rectifier (PFC) and dual-inverter PWM drive stage. It brings the PFC up first, waits for the DC bus, and then enables both inverters. After a protection trip it holds a cooldown, pulses the drive's latch reset, and retries. Repeated trips inside a time window latch a lockout that only an explicit clear releases. It sits between the DSP run commands and the PWM drive's enable and reset inputs, on CLK_50M.

## Interface
Parameters:
- SOFTSTART_CYC, 50000: maximum wait for bus_ready after PFC enable (1 ms).
- COOLDOWN_CYC, 500000: hold-off after a trip before retry (10 ms).
- RETRY_WINDOW_CYC, 5000000: trip-counting window (100 ms).
- MAX_RETRY, 3: trips inside the window that cause lockout.
- RST_PULSE_CYC, 4: width of reset_pulse.
- WDOG_CYC, 250000: heartbeat timeout (only with PWM_SEQ_WDOG_EN).

Ports:
- CLK_50M  in  1  system clock.
- Rst_n  in  1  reset, asynchronous assert, active-low.
- start_req  in  1  level, DSP run command.
- stop_req  in  1  level, orderly stop.
- clr_lock  in  1  single-cycle pulse, clears lockout.
- pfc_ok  in  1  1 = PFC protection healthy (drive CP1).
- inv1_ok, inv2_ok  in  1 each  1 = inverter protection healthy.
- bus_ready  in  1  1 = bus voltage in range.
- dsp_hb  in  1  DSP heartbeat toggle.
- pfc_run  out  1  PFC enable to drive.
- inv_run  out  1  inverter enable to drive.
- reset_pulse  out  1  protection-latch reset to drive (Reset_D).
- lockout  out  1  permanent-fault flag.
- state  out  3  current state encoding.
- retry_cnt  out  2  trips in the current window.
- fault_src  out  5  sticky cause bits: [0] pfc, [1] inv1, [2] inv2, [3] start timeout, [4] watchdog.

## Operation
- All asynchronous inputs except clr_lock pass through 2-flop synchronizers. clr_lock is already synchronous.
- States: IDLE=0, PFC_START=1, RUN=2, COOLDOWN=3, RETRY_RST=4, LOCKOUT=5.
- IDLE: all run outputs 0. On start_req=1 and stop_req=0: clear fault_src, go to PFC_START, load the timer.
- PFC_START: pfc_run=1.
  - bus_ready=1 → RUN.
  - Timer reaches SOFTSTART_CYC → trip with fault_src[3].
- RUN: pfc_run=1, inv_run=1.
- Trip, from PFC_START or RUN: any synchronized ok input low, or timeout.
  - OR the cause bits into fault_src.
  - Drop all run outputs.
  - Increment retry_cnt. Start the window counter if retry_cnt was 0.
  - If the new retry_cnt equals MAX_RETRY → LOCKOUT; otherwise → COOLDOWN.
- COOLDOWN: after COOLDOWN_CYC cycles → RETRY_RST.
- RETRY_RST: reset_pulse=1 for RST_PULSE_CYC cycles, then → PFC_START if start_req=1, else → IDLE.
- LOCKOUT: lockout=1, all run outputs 0. Only clr_lock exits: → IDLE, clear retry_cnt and the window counter. fault_src is held.
- Window: when the window counter reaches RETRY_WINDOW_CYC, retry_cnt clears to 0. The counter is idle while retry_cnt=0.
- stop_req=1 in any state except LOCKOUT → IDLE next cycle. retry_cnt is kept.
- Priority, same cycle: stop_req > trip > timer or bus_ready events. clr_lock outside LOCKOUT is ignored.
- A trip that coincides with window expiry counts into the fresh window, so retry_cnt = 1.
- Counters saturate and never wrap.

## Timing
- Reset values: state=IDLE, every output 0, all counters 0.
- Outputs are registered.
- ok-low → run outputs low: 3 cycles (2 for the synchronizer, 1 for the state register).
- start_req → pfc_run: 3 cycles.
- bus_ready → inv_run: 3 cycles.
- reset_pulse is exactly RST_PULSE_CYC cycles wide.
- Async reset mid-operation: outputs go to 0 immediately. Lockout is not retained across reset.

## Configuration
- PWM_SEQ_WDOG_EN defined: a toggle of synchronized dsp_hb reloads a WDOG_CYC counter. Expiry while in PFC_START or RUN is a trip with fault_src[4].
- Not defined: dsp_hb is ignored, fault_src[4] is tied to 0, and the counter is not built.

## Structure
- Package pwm_seq_pkg holds:
  - the state enum,
  - the fault_src bit indices,
  - a helper function computing counter widths from the parameters.
- Sub-module pwm_seq_sync: a parameterized-width 2-flop synchronizer with async active-low reset, instantiated once for all level inputs.

## Test plan
All scenarios use SOFTSTART_CYC=100, COOLDOWN_CYC=200, RETRY_WINDOW_CYC=1000, MAX_RETRY=3, RST_PULSE_CYC=4.
- start_req=1, bus_ready rises 20 cycles later → pfc_run at cycle 3, inv_run 3 cycles after bus_ready, state=RUN.
- bus_ready held 0 → trip at 100 cycles, fault_src=5'b01000, COOLDOWN, then reset_pulse 4 cycles wide, then PFC_START again.
- inv2_ok low for 1 cycle in RUN → run outputs 0 within 3 cycles, retry_cnt=1, fault_src=5'b00100.
- 3 pfc_ok trips within 1000 cycles → lockout=1, state=LOCKOUT. start_req is ignored. clr_lock → IDLE with retry_cnt=0.
- 2 trips, then 1000 quiet cycles, then a third trip → retry_cnt=1, no lockout.
- With PWM_SEQ_WDOG_EN and WDOG_CYC=300, dsp_hb frozen in RUN → trip with fault_src[4]=1. Without the macro, the same stimulus causes no trip.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types for the PFC/inverter start-up and fault-retry sequencer: state encoding,
// fault cause bit positions, synchronizer lane map and counter-width helpers.
package pwm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PFC_START = 3'd1,
        ST_RUN       = 3'd2,
        ST_COOLDOWN  = 3'd3,
        ST_RETRY_RST = 3'd4,
        ST_LOCKOUT   = 3'd5
    } seq_state_t;

    localparam int FS_PFC     = 0;
    localparam int FS_INV1    = 1;
    localparam int FS_INV2    = 2;
    localparam int FS_TIMEOUT = 3;
    localparam int FS_WDOG    = 4;

    localparam int SI_START = 0;
    localparam int SI_STOP  = 1;
    localparam int SI_PFC   = 2;
    localparam int SI_INV1  = 3;
    localparam int SI_INV2  = 4;
    localparam int SI_BUS   = 5;
    localparam int SI_HB    = 6;
    localparam int SYNC_W   = 7;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pwm_seq_sync.sv
// Multi-bit 2-flop synchronizer for independent level inputs.
// Latency: 2 cycles; no backpressure.
module pwm_seq_sync #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pwm_fault_sequencer.sv
// PFC-then-inverter start-up, trip/cooldown/retry and windowed lockout sequencer.
// Latency: inputs to outputs 3 cycles; no backpressure. PWM_SEQ_WDOG_EN adds a heartbeat watchdog.
module pwm_fault_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned SOFTSTART_CYC    = 50000,
    parameter int unsigned COOLDOWN_CYC     = 500000,
    parameter int unsigned RETRY_WINDOW_CYC = 5000000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned RST_PULSE_CYC    = 4,
    parameter int unsigned WDOG_CYC         = 250000
) (
    input  logic       CLK_50M,
    input  logic       Rst_n,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       clr_lock,
    input  logic       pfc_ok,
    input  logic       inv1_ok,
    input  logic       inv2_ok,
    input  logic       bus_ready,
    input  logic       dsp_hb,
    output logic       pfc_run,
    output logic       inv_run,
    output logic       reset_pulse,
    output logic       lockout,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic [4:0] fault_src
);

    localparam int unsigned    TMR_MAX = max3(SOFTSTART_CYC, COOLDOWN_CYC, RST_PULSE_CYC);
    localparam int             TMR_W   = cnt_w(TMR_MAX);
    localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0] SS_LAST = TMR_W'(SOFTSTART_CYC - 1);
    localparam logic [TMR_W-1:0] CD_LAST = TMR_W'(COOLDOWN_CYC - 1);
    localparam logic [TMR_W-1:0] RP_LAST = TMR_W'(RST_PULSE_CYC - 1);
    localparam int             WIN_W   = cnt_w(RETRY_WINDOW_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RETRY_WINDOW_CYC - 1);
    localparam logic [1:0]     MAX_R   = 2'(MAX_RETRY);

    logic [SYNC_W-1:0] w_sync;
    logic              w_start;
    logic              w_stop;
    logic              w_bus;
    logic              w_hb;
    logic              w_active;
    logic              w_timeout;
    logic              w_wdog_exp;
    logic              w_win_exp;
    logic              w_trip;
    logic [4:0]        w_cause;
    logic [1:0]        w_retry_base;
    logic [1:0]        w_retry_next;

    seq_state_t        r_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [1:0]        r_retry_cnt;
    logic [4:0]        r_fault_src;
    logic              r_pfc_run;
    logic              r_inv_run;
    logic              r_rst_pulse;
    logic              r_lockout;

    pwm_seq_sync #(.W(SYNC_W)) u_sync (
        .i_clk   (CLK_50M),
        .i_rst_n (Rst_n),
        .i_d     ({dsp_hb, bus_ready, inv2_ok, inv1_ok, pfc_ok, stop_req, start_req}),
        .o_q     (w_sync)
    );

    assign w_start = w_sync[SI_START];
    assign w_stop  = w_sync[SI_STOP];
    assign w_bus   = w_sync[SI_BUS];
    assign w_hb    = w_sync[SI_HB];

`ifdef PWM_SEQ_WDOG_EN
    localparam int             WD_W    = cnt_w(WDOG_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    logic            r_hb_d;
    logic [WD_W-1:0] r_wdog_cnt;

    // Any heartbeat edge restarts the count; the counter parks at expiry until one arrives.
    always_ff @(posedge CLK_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hb_d     <= 1'b0;
            r_wdog_cnt <= '0;
        end else begin
            r_hb_d <= w_hb;
            if (w_hb ^ r_hb_d)
                r_wdog_cnt <= '0;
            else if (r_wdog_cnt != WD_LAST)
                r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
        end
    end

    assign w_wdog_exp = (r_wdog_cnt == WD_LAST);
`else
    logic                     w_unused_hb;
    localparam int unsigned   unused_wdog_cyc = WDOG_CYC;
    assign w_unused_hb = w_hb;
    assign w_wdog_exp  = 1'b0;
`endif

    assign w_active  = (r_state == ST_PFC_START) || (r_state == ST_RUN);
    assign w_timeout = (r_state == ST_PFC_START) && (r_tmr == SS_LAST);

    assign w_cause[FS_PFC]     = ~w_sync[SI_PFC];
    assign w_cause[FS_INV1]    = ~w_sync[SI_INV1];
    assign w_cause[FS_INV2]    = ~w_sync[SI_INV2];
    assign w_cause[FS_TIMEOUT] = w_timeout;
    assign w_cause[FS_WDOG]    = w_wdog_exp;

    assign w_trip = w_active && (|w_cause);

    // Window is frozen in lockout so retry_cnt keeps showing the trip count until cleared.
    assign w_win_exp    = (r_retry_cnt != 2'd0) && (r_state != ST_LOCKOUT) && (r_win_cnt == WIN_LAST);
    assign w_retry_base = w_win_exp ? 2'd0 : r_retry_cnt;
    assign w_retry_next = (w_retry_base == MAX_R) ? w_retry_base : w_retry_base + 2'd1;

    always_ff @(posedge CLK_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_win_cnt   <= '0;
            r_retry_cnt <= 2'd0;
            r_fault_src <= 5'd0;
            r_pfc_run   <= 1'b0;
            r_inv_run   <= 1'b0;
            r_rst_pulse <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            r_tmr <= (r_tmr == TMR_TOP) ? r_tmr : r_tmr + TMR_W'(1);

            if (w_win_exp) begin
                r_retry_cnt <= 2'd0;
                r_win_cnt   <= '0;
            end else if ((r_retry_cnt != 2'd0) && (r_state != ST_LOCKOUT)) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            end

            if (w_stop && (r_state != ST_LOCKOUT)) begin
                r_state     <= ST_IDLE;
                r_pfc_run   <= 1'b0;
                r_inv_run   <= 1'b0;
                r_rst_pulse <= 1'b0;
            end else if (w_trip) begin
                // A trip on the window-expiry cycle lands in the fresh window via w_retry_base.
                r_fault_src <= r_fault_src | w_cause;
                r_pfc_run   <= 1'b0;
                r_inv_run   <= 1'b0;
                r_tmr       <= '0;
                r_retry_cnt <= w_retry_next;
                if (w_retry_next == MAX_R) begin
                    r_state   <= ST_LOCKOUT;
                    r_lockout <= 1'b1;
                end else begin
                    r_state <= ST_COOLDOWN;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_fault_src <= 5'd0;
                            r_state     <= ST_PFC_START;
                            r_pfc_run   <= 1'b1;
                            r_tmr       <= '0;
                        end
                    end
                    ST_PFC_START: begin
                        if (w_bus) begin
                            r_state   <= ST_RUN;
                            r_inv_run <= 1'b1;
                        end
                    end
                    ST_RUN: ;
                    ST_COOLDOWN: begin
                        if (r_tmr == CD_LAST) begin
                            r_state     <= ST_RETRY_RST;
                            r_rst_pulse <= 1'b1;
                            r_tmr       <= '0;
                        end
                    end
                    ST_RETRY_RST: begin
                        if (r_tmr == RP_LAST) begin
                            r_rst_pulse <= 1'b0;
                            r_tmr       <= '0;
                            if (w_start) begin
                                r_state   <= ST_PFC_START;
                                r_pfc_run <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_LOCKOUT: begin
                        if (clr_lock) begin
                            r_state     <= ST_IDLE;
                            r_lockout   <= 1'b0;
                            r_retry_cnt <= 2'd0;
                            r_win_cnt   <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pfc_run     = r_pfc_run;
    assign inv_run     = r_inv_run;
    assign reset_pulse = r_rst_pulse;
    assign lockout     = r_lockout;
    assign state       = r_state;
    assign retry_cnt   = r_retry_cnt;
    assign fault_src   = r_fault_src;

endmodule

// File: tb/tb_pwm_fault_sequencer.sv
// Directed bench for pwm_fault_sequencer: vector table for the start/stop/trip path,
// hand sequences for soft-start timeout, lockout, retry window, watchdog and async reset.
module tb_pwm_fault_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_req = 1'b0, stop_req = 1'b0, clr_lock = 1'b0;
    logic       pfc_ok = 1'b1, inv1_ok = 1'b1, inv2_ok = 1'b1, bus_ready = 1'b0;
    logic       dsp_hb = 1'b0;
    logic       hb_en = 1'b1;
    logic       pfc_run, inv_run, reset_pulse, lockout;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [4:0] fault_src;

    int n_total = 0;
    int n_bad   = 0;

    pwm_fault_sequencer #(
        .SOFTSTART_CYC(100), .COOLDOWN_CYC(200), .RETRY_WINDOW_CYC(1000),
        .MAX_RETRY(3), .RST_PULSE_CYC(4), .WDOG_CYC(300)
    ) dut (
        .CLK_50M(clk), .Rst_n(rst_n), .start_req(start_req), .stop_req(stop_req),
        .clr_lock(clr_lock), .pfc_ok(pfc_ok), .inv1_ok(inv1_ok), .inv2_ok(inv2_ok),
        .bus_ready(bus_ready), .dsp_hb(dsp_hb), .pfc_run(pfc_run), .inv_run(inv_run),
        .reset_pulse(reset_pulse), .lockout(lockout), .state(state),
        .retry_cnt(retry_cnt), .fault_src(fault_src)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (hb_en) dsp_hb = ~dsp_hb;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_req = 0; stop_req = 0; clr_lock = 0;
        pfc_ok = 1; inv1_ok = 1; inv2_ok = 1; bus_ready = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_state(input int tgt, input int bound, input string nm);
        int k = 0;
        while (int'(state) != tgt && k < bound) begin
            tick();
            k++;
        end
        check(nm, state, tgt);
    endtask

    // Single-cycle pfc_ok dropout from RUN, then settle past the 3-cycle trip latency.
    task automatic pfc_trip(input string nm);
        wait_state(2, 600, {nm, ".reach_run"});
        pfc_ok = 1'b0;
        tick();
        pfc_ok = 1'b1;
        tick();
        tick();
    endtask

    typedef struct {
        int start, stop, pfc, i1, i2, bus, clr, hold;
        int st, prun, irun, lock, rc, fs;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    initial begin
        int n;
        //          start stop pfc i1 i2 bus clr hold | st prun irun lock rc fs
        vt[0]  = '{0, 0, 1, 1, 1, 0, 0,  5,  0, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 1, 1, 1, 0, 0,  2,  0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 0, 1, 1, 1, 0, 0,  1,  1, 1, 0, 0, 0, 0};
        vt[3]  = '{1, 0, 1, 1, 1, 0, 0, 17,  1, 1, 0, 0, 0, 0};
        vt[4]  = '{1, 0, 1, 1, 1, 1, 0,  2,  1, 1, 0, 0, 0, 0};
        vt[5]  = '{1, 0, 1, 1, 1, 1, 0,  1,  2, 1, 1, 0, 0, 0};
        vt[6]  = '{1, 0, 1, 1, 1, 1, 1,  3,  2, 1, 1, 0, 0, 0};
        vt[7]  = '{1, 1, 1, 1, 1, 1, 0,  3,  0, 0, 0, 0, 0, 0};
        vt[8]  = '{1, 0, 1, 1, 1, 1, 0,  3,  1, 1, 0, 0, 0, 0};
        vt[9]  = '{1, 0, 1, 1, 1, 1, 0,  1,  2, 1, 1, 0, 0, 0};
        vt[10] = '{1, 0, 1, 1, 0, 1, 0,  1,  2, 1, 1, 0, 0, 0};
        vt[11] = '{1, 0, 1, 1, 1, 1, 0,  1,  2, 1, 1, 0, 0, 0};
        vt[12] = '{1, 0, 1, 1, 1, 1, 0,  1,  3, 0, 0, 0, 1, 4};
        vt[13] = '{0, 1, 1, 1, 1, 1, 0,  3,  0, 0, 0, 0, 1, 4};
        vt[14] = '{1, 0, 1, 1, 1, 1, 0,  3,  1, 1, 0, 0, 1, 0};

        tick();
        check("rst.state", state, 0);
        check("rst.pfc_run", pfc_run, 0);
        check("rst.inv_run", inv_run, 0);
        check("rst.reset_pulse", reset_pulse, 0);
        check("rst.lockout", lockout, 0);
        check("rst.retry_cnt", retry_cnt, 0);
        check("rst.fault_src", fault_src, 0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            start_req = vt[i].start[0]; stop_req = vt[i].stop[0];
            pfc_ok = vt[i].pfc[0]; inv1_ok = vt[i].i1[0]; inv2_ok = vt[i].i2[0];
            bus_ready = vt[i].bus[0]; clr_lock = vt[i].clr[0];
            repeat (vt[i].hold) tick();
            check($sformatf("v%0d.state", i), state, vt[i].st);
            check($sformatf("v%0d.pfc_run", i), pfc_run, vt[i].prun);
            check($sformatf("v%0d.inv_run", i), inv_run, vt[i].irun);
            check($sformatf("v%0d.lockout", i), lockout, vt[i].lock);
            check($sformatf("v%0d.retry_cnt", i), retry_cnt, vt[i].rc);
            check($sformatf("v%0d.fault_src", i), fault_src, vt[i].fs);
        end
        clr_lock = 1'b0;

        // Soft-start timeout, cooldown length, reset pulse width, automatic retry.
        do_reset();
        start_req = 1'b1;
        n = 0;
        while (!pfc_run && n < 10) begin tick(); n++; end
        check("A.pfc_on", pfc_run, 1);
        n = 0;
        while (pfc_run && n < 1000) begin n++; tick(); end
        check("A.softstart_len", n, 100);
        check("A.state_cool", state, 3);
        check("A.fault_src", fault_src, 5'b01000);
        check("A.retry_cnt", retry_cnt, 1);
        n = 0;
        while (int'(state) == 3 && n < 1000) begin n++; tick(); end
        check("A.cooldown_len", n, 200);
        n = 0;
        while (reset_pulse && n < 100) begin n++; tick(); end
        check("A.rst_pulse_len", n, 4);
        check("A.state_retry", state, 1);
        check("A.pfc_rerun", pfc_run, 1);

        // Three trips inside the window latch lockout; only clr_lock releases it.
        do_reset();
        start_req = 1'b1; bus_ready = 1'b1;
        pfc_trip("B1");
        check("B1.retry_cnt", retry_cnt, 1);
        pfc_trip("B2");
        check("B2.retry_cnt", retry_cnt, 2);
        pfc_trip("B3");
        check("B3.state", state, 5);
        check("B3.lockout", lockout, 1);
        check("B3.pfc_run", pfc_run, 0);
        check("B3.fault_src", fault_src, 5'b00001);
        repeat (20) tick();
        check("B.start_ignored", state, 5);
        stop_req = 1'b1;
        repeat (5) tick();
        check("B.stop_ignored", state, 5);
        stop_req = 1'b0;
        repeat (3) tick();
        clr_lock = 1'b1;
        tick();
        clr_lock = 1'b0;
        check("B.clr_state", state, 0);
        check("B.clr_retry", retry_cnt, 0);
        check("B.clr_lockout", lockout, 0);
        check("B.fault_held", fault_src, 5'b00001);

        // Window expiry between trips restarts the count.
        do_reset();
        start_req = 1'b1; bus_ready = 1'b1;
        pfc_trip("C1");
        pfc_trip("C2");
        check("C2.retry_cnt", retry_cnt, 2);
        wait_state(2, 600, "C.back_in_run");
        repeat (1000) tick();
        check("C.window_clear", retry_cnt, 0);
        pfc_trip("C3");
        check("C3.retry_cnt", retry_cnt, 1);
        check("C3.lockout", lockout, 0);
        check("C3.state", state, 3);

        // Frozen heartbeat in RUN.
        hb_en = 1'b0;
        do_reset();
        start_req = 1'b1; bus_ready = 1'b1;
        repeat (400) tick();
`ifdef PWM_SEQ_WDOG_EN
        check("D.wdog_fault", fault_src[4], 1);
`else
        check("D.no_wdog_state", state, 2);
        check("D.no_wdog_fault", fault_src, 0);
`endif

        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        #2 rst_n = 1'b0;
        #1;
        check("E.async_pfc_run", pfc_run, 0);
        check("E.async_inv_run", inv_run, 0);
        check("E.async_state", state, 0);
        check("E.async_lockout", lockout, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
